// File: rtl/cdb_arbiter.sv
// cdb_arbiter: collects FU writeback results in per-FU FIFOs and round-robins them onto one registered CDB.
// Build macro CDB_PERF_EN adds saturating stall and broadcast counters.
module cdb_arbiter #(
    parameter int FU_NUM    = 4,
    parameter int BUF_DEPTH = 2,
    parameter int PHYS_W    = 7,
    parameter int ROB_W     = 6,
    parameter int EPOCH_W   = 2,
    parameter int XLEN      = 32,
    localparam int SRC_W    = (FU_NUM > 1) ? $clog2(FU_NUM) : 1,
    localparam int PTR_W    = $clog2(BUF_DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [FU_NUM-1:0]                 fu_wb_valid,
    output logic [FU_NUM-1:0]                 fu_wb_ready,
    input  logic [FU_NUM-1:0][PHYS_W-1:0]     fu_wb_pd,
    input  logic [FU_NUM-1:0][XLEN-1:0]       fu_wb_data,
    input  logic [FU_NUM-1:0][ROB_W-1:0]      fu_wb_rob_idx,
    input  logic [FU_NUM-1:0][EPOCH_W-1:0]    fu_wb_epoch,
    output logic                              cdb_valid,
    input  logic                              cdb_ready,
    output logic [PHYS_W-1:0]                 cdb_pd,
    output logic [XLEN-1:0]                   cdb_data,
    output logic [ROB_W-1:0]                  cdb_rob_idx,
    output logic [EPOCH_W-1:0]                cdb_epoch,
    output logic [SRC_W-1:0]                  cdb_src,
    input  logic                              flush_valid,
    input  logic                              recover_valid,
    input  logic [ROB_W-1:0]                  recover_rob_idx,
    input  logic [EPOCH_W-1:0]                recover_epoch,
    output logic                              busy
`ifdef CDB_PERF_EN
    ,
    output logic [31:0]                       perf_stall_cycles,
    output logic [31:0]                       perf_bcast_count
`endif
);

    typedef struct packed {
        logic [PHYS_W-1:0]  pd;
        logic [XLEN-1:0]    data;
        logic [ROB_W-1:0]   rob_idx;
        logic [EPOCH_W-1:0] epoch;
    } entry_t;

    entry_t               mem    [FU_NUM][BUF_DEPTH];
    logic [BUF_DEPTH-1:0] killed [FU_NUM];
    logic [PTR_W-1:0]     wr_ptr [FU_NUM];
    logic [PTR_W-1:0]     rd_ptr [FU_NUM];
    logic [CNT_W-1:0]     count  [FU_NUM];
    logic [SRC_W-1:0]     rr_ptr;

    entry_t               head   [FU_NUM];
    logic [FU_NUM-1:0]    nonempty;
    logic [FU_NUM-1:0]    head_dead;
    logic [FU_NUM-1:0]    eligible;
    logic [FU_NUM-1:0]    push;
    logic [FU_NUM-1:0]    pop;
    logic                 any_elig;
    logic [SRC_W-1:0]     winner;
    logic                 out_hit;
    logic                 stage_free;
    logic                 load;

    // Ready comes purely from registered occupancy, so it never depends on cdb_ready.
    always_comb begin
        for (int f = 0; f < FU_NUM; f++) begin
            head[f]        = mem[f][rd_ptr[f]];
            nonempty[f]    = (count[f] != '0);
            fu_wb_ready[f] = (count[f] != CNT_W'(BUF_DEPTH));
        end
    end

    // A head matching a same-cycle recover is treated as already killed.
    always_comb begin
        for (int f = 0; f < FU_NUM; f++) begin
            head_dead[f] = nonempty[f] &&
                           (killed[f][rd_ptr[f]] ||
                            (recover_valid &&
                             head[f].rob_idx == recover_rob_idx &&
                             head[f].epoch   == recover_epoch));
            eligible[f]  = nonempty[f] && !head_dead[f];
            push[f]      = fu_wb_valid[f] && fu_wb_ready[f] && !flush_valid;
        end
    end

    always_comb begin
        int               tmp;
        logic [SRC_W-1:0] idx;
        tmp      = 0;
        idx      = '0;
        winner   = '0;
        any_elig = 1'b0;
        for (int k = 0; k < FU_NUM; k++) begin
            tmp = int'(rr_ptr) + k;
            if (tmp >= FU_NUM) tmp = tmp - FU_NUM;
            idx = SRC_W'(tmp);
            if (!any_elig && eligible[idx]) begin
                any_elig = 1'b1;
                winner   = idx;
            end
        end
    end

    assign out_hit    = cdb_valid && recover_valid &&
                        cdb_rob_idx == recover_rob_idx && cdb_epoch == recover_epoch;
    assign stage_free = !cdb_valid || cdb_ready || out_hit;
    assign load       = stage_free && any_elig && !flush_valid;

    always_comb begin
        for (int f = 0; f < FU_NUM; f++) begin
            pop[f] = head_dead[f] || (load && winner == SRC_W'(f));
        end
    end

    assign busy = cdb_valid || (|nonempty);

    // NOTE: payload storage has no reset; occupancy counters qualify every read, so stale data is never used.
    always_ff @(posedge clk) begin
        for (int f = 0; f < FU_NUM; f++) begin
            if (push[f]) begin
                mem[f][wr_ptr[f]] <= '{pd:      fu_wb_pd[f],
                                       data:    fu_wb_data[f],
                                       rob_idx: fu_wb_rob_idx[f],
                                       epoch:   fu_wb_epoch[f]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_valid) begin
            for (int f = 0; f < FU_NUM; f++) begin
                wr_ptr[f] <= '0;
                rd_ptr[f] <= '0;
                count[f]  <= '0;
                killed[f] <= '0;
            end
        end else begin
            for (int f = 0; f < FU_NUM; f++) begin
                // Kill marks on stale slots are harmless: a push rewrites the flag.
                for (int e = 0; e < BUF_DEPTH; e++) begin
                    if (recover_valid && mem[f][e].rob_idx == recover_rob_idx &&
                        mem[f][e].epoch == recover_epoch) begin
                        killed[f][e] <= 1'b1;
                    end
                end
                if (push[f]) begin
                    killed[f][wr_ptr[f]] <= recover_valid &&
                                            fu_wb_rob_idx[f] == recover_rob_idx &&
                                            fu_wb_epoch[f] == recover_epoch;
                    wr_ptr[f] <= wr_ptr[f] + PTR_W'(1);
                end
                if (pop[f]) begin
                    rd_ptr[f] <= rd_ptr[f] + PTR_W'(1);
                end
                count[f] <= count[f] + CNT_W'(push[f]) - CNT_W'(pop[f]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid   <= 1'b0;
            cdb_pd      <= '0;
            cdb_data    <= '0;
            cdb_rob_idx <= '0;
            cdb_epoch   <= '0;
            cdb_src     <= '0;
            rr_ptr      <= '0;
        end else if (flush_valid) begin
            cdb_valid <= 1'b0;
            rr_ptr    <= '0;
        end else if (load) begin
            cdb_valid   <= 1'b1;
            cdb_pd      <= head[winner].pd;
            cdb_data    <= head[winner].data;
            cdb_rob_idx <= head[winner].rob_idx;
            cdb_epoch   <= head[winner].epoch;
            cdb_src     <= winner;
            rr_ptr      <= (winner == SRC_W'(FU_NUM - 1)) ? '0 : winner + SRC_W'(1);
        end else if (stage_free) begin
            cdb_valid <= 1'b0;
        end
    end

`ifdef CDB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_bcast_count  <= '0;
        end else begin
            if (cdb_valid && !cdb_ready && perf_stall_cycles != '1) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (cdb_valid && cdb_ready && perf_bcast_count != '1) begin
                perf_bcast_count <= perf_bcast_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a queue of expected broadcasts is filled as FU pushes are accepted
// and drained by a monitor that compares every CDB handshake.
module tb_cdb_arbiter;

    localparam int FU_NUM = 4;
    localparam int BUF_D  = 2;
    localparam int PW     = 7;
    localparam int RW     = 6;
    localparam int EW     = 2;
    localparam int XL     = 32;
    localparam int SW     = 2;

    logic                         clk;
    logic                         rst;
    logic [FU_NUM-1:0]            fu_wb_valid;
    logic [FU_NUM-1:0]            fu_wb_ready;
    logic [FU_NUM-1:0][PW-1:0]    fu_wb_pd;
    logic [FU_NUM-1:0][XL-1:0]    fu_wb_data;
    logic [FU_NUM-1:0][RW-1:0]    fu_wb_rob_idx;
    logic [FU_NUM-1:0][EW-1:0]    fu_wb_epoch;
    logic                         cdb_valid;
    logic                         cdb_ready;
    logic [PW-1:0]                cdb_pd;
    logic [XL-1:0]                cdb_data;
    logic [RW-1:0]                cdb_rob_idx;
    logic [EW-1:0]                cdb_epoch;
    logic [SW-1:0]                cdb_src;
    logic                         flush_valid;
    logic                         recover_valid;
    logic [RW-1:0]                recover_rob_idx;
    logic [EW-1:0]                recover_epoch;
    logic                         busy;
`ifdef CDB_PERF_EN
    logic [31:0]                  perf_stall_cycles;
    logic [31:0]                  perf_bcast_count;
`endif

    cdb_arbiter #(
        .FU_NUM(FU_NUM), .BUF_DEPTH(BUF_D), .PHYS_W(PW),
        .ROB_W(RW), .EPOCH_W(EW), .XLEN(XL)
    ) dut (
        .clk(clk), .rst(rst),
        .fu_wb_valid(fu_wb_valid), .fu_wb_ready(fu_wb_ready),
        .fu_wb_pd(fu_wb_pd), .fu_wb_data(fu_wb_data),
        .fu_wb_rob_idx(fu_wb_rob_idx), .fu_wb_epoch(fu_wb_epoch),
        .cdb_valid(cdb_valid), .cdb_ready(cdb_ready),
        .cdb_pd(cdb_pd), .cdb_data(cdb_data),
        .cdb_rob_idx(cdb_rob_idx), .cdb_epoch(cdb_epoch), .cdb_src(cdb_src),
        .flush_valid(flush_valid), .recover_valid(recover_valid),
        .recover_rob_idx(recover_rob_idx), .recover_epoch(recover_epoch),
        .busy(busy)
`ifdef CDB_PERF_EN
        , .perf_stall_cycles(perf_stall_cycles), .perf_bcast_count(perf_bcast_count)
`endif
    );

    typedef struct {
        logic [PW-1:0] pd;
        logic [XL-1:0] data;
        logic [RW-1:0] rob;
        logic [EW-1:0] ep;
        int            src;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;
    logic rr_chk = 1'b0;
    int   exp_src = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Enqueue what the DUT accepts at the coming edge, apply flush/recover to the model, then advance.
    task automatic drive_step();
        exp_t e;
        if (!rst && !flush_valid) begin
            for (int f = 0; f < FU_NUM; f++) begin
                if (fu_wb_valid[f] && fu_wb_ready[f]) begin
                    e.pd   = fu_wb_pd[f];
                    e.data = fu_wb_data[f];
                    e.rob  = fu_wb_rob_idx[f];
                    e.ep   = fu_wb_epoch[f];
                    e.src  = f;
                    sb.push_back(e);
                end
            end
        end
        if (flush_valid) sb.delete();
        if (recover_valid) begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].rob == recover_rob_idx && sb[i].ep == recover_epoch) sb.delete(i);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_fu(input int f, input int pd, input int data, input int rob, input int ep);
        fu_wb_valid[f]   = 1'b1;
        fu_wb_pd[f]      = PW'(pd);
        fu_wb_data[f]    = XL'(data);
        fu_wb_rob_idx[f] = RW'(rob);
        fu_wb_epoch[f]   = EW'(ep);
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        fu_wb_valid     = '0;
        fu_wb_pd        = '0;
        fu_wb_data      = '0;
        fu_wb_rob_idx   = '0;
        fu_wb_epoch     = '0;
        cdb_ready       = 1'b0;
        flush_valid     = 1'b0;
        recover_valid   = 1'b0;
        recover_rob_idx = '0;
        recover_epoch   = '0;
        drive_step();
        drive_step();
        rst = 1'b0;
        sb.delete();
    endtask

    // Monitor: every handshake must match the oldest expected entry from the same FU.
    always @(negedge clk) begin : monitor
        int hit;
        hit = -1;
        if (!rst && cdb_valid && cdb_ready) begin
            for (int i = 0; i < sb.size(); i++) begin
                if (hit < 0 && sb[i].src == int'(cdb_src)) hit = i;
            end
            check("bcast_known", 64'(hit >= 0), 64'd1);
            if (hit >= 0) begin
                check("bcast_payload", {cdb_pd, cdb_data, cdb_rob_idx, cdb_epoch},
                      {sb[hit].pd, sb[hit].data, sb[hit].rob, sb[hit].ep});
                sb.delete(hit);
            end
            if (rr_chk) begin
                check("rr_src", 64'(cdb_src), 64'(exp_src));
                exp_src = (exp_src + 1) % FU_NUM;
            end
        end
    end

    initial begin
        rst = 1'b1;

        // Reset state
        do_reset();
        check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
        check("rst_cdb_fields", {cdb_pd, cdb_data, cdb_rob_idx, cdb_epoch, cdb_src}, 64'd0);
        check("rst_ready", 64'(fu_wb_ready), 64'hF);
        check("rst_busy", 64'(busy), 64'd0);

        // Single push: two-cycle latency, one-cycle broadcast
        cdb_ready = 1'b1;
        push_fu(0, 5, 32'hAB, 1, 0);
        drive_step();
        check("single_lat_valid", 64'(cdb_valid), 64'd0);
        check("single_lat_busy", 64'(busy), 64'd1);
        fu_wb_valid = '0;
        drive_step();
        check("single_bcast", {cdb_valid, cdb_src, cdb_pd, cdb_data}, {1'b1, 2'd0, 7'd5, 32'hAB});
        drive_step();
        check("single_done_valid", 64'(cdb_valid), 64'd0);
        check("single_done_busy", 64'(busy), 64'd0);

        // All FUs push every cycle: strict rotation, no gaps, ready drops when full
        do_reset();
        cdb_ready = 1'b1;
        rr_chk    = 1'b1;
        exp_src   = 0;
        for (int c = 0; c < 14; c++) begin
            for (int f = 0; f < FU_NUM; f++) push_fu(f, f * 32 + c, f * 1000 + c, c, f);
            drive_step();
            if (c == 1) check("rr_ready_e2", 64'(fu_wb_ready), 64'b0001);
            if (c == 2) check("rr_ready_e3", 64'(fu_wb_ready), 64'b0010);
            if (c >= 1) check("rr_no_gap", 64'(cdb_valid), 64'd1);
        end
        rr_chk      = 1'b0;
        fu_wb_valid = '0;
        for (int i = 0; i < 12; i++) drive_step();
        check("rr_drained", 64'(sb.size()), 64'd0);
        check("rr_busy", 64'(busy), 64'd0);

        // Stall: outputs hold, FU1 fills and stays not-ready until the first handshake
        do_reset();
        cdb_ready = 1'b0;
        push_fu(1, 9, 32'h99, 9, 0);
        drive_step();
        push_fu(1, 10, 32'h100, 10, 0);
        drive_step();
        check("stall_first", {cdb_valid, cdb_src, cdb_pd, cdb_data}, {1'b1, 2'd1, 7'd9, 32'h99});
        push_fu(1, 11, 32'h101, 11, 0);
        drive_step();
        fu_wb_valid = '0;
        for (int i = 0; i < 5; i++) begin
            check("stall_hold", {cdb_valid, cdb_src, cdb_pd, cdb_data}, {1'b1, 2'd1, 7'd9, 32'h99});
            check("stall_ready1", 64'(fu_wb_ready[1]), 64'd0);
            drive_step();
        end
        cdb_ready = 1'b1;
        drive_step();
        check("stall_ready1_back", 64'(fu_wb_ready[1]), 64'd1);
        check("stall_next_pd", 64'(cdb_pd), 64'd10);
        drive_step();
        drive_step();
        check("stall_drained", 64'(sb.size()), 64'd0);
        check("stall_busy", 64'(busy), 64'd0);

        // Recover kills buffered rob 4 and a same-cycle matching push; 3 then 5 broadcast
        do_reset();
        cdb_ready = 1'b0;
        push_fu(2, 3, 32'h300, 3, 1);
        drive_step();
        push_fu(2, 4, 32'h400, 4, 1);
        drive_step();
        push_fu(2, 5, 32'h500, 5, 1);
        drive_step();
        fu_wb_valid = '0;
        push_fu(0, 20, 32'h2000, 4, 1);
        recover_valid   = 1'b1;
        recover_rob_idx = 6'd4;
        recover_epoch   = 2'd1;
        drive_step();
        recover_valid = 1'b0;
        fu_wb_valid   = '0;
        check("recover_cdb_kept", {cdb_valid, cdb_pd}, {1'b1, 7'd3});
        drive_step();
        cdb_ready = 1'b1;
        for (int i = 0; i < 4; i++) drive_step();
        check("recover_drained", 64'(sb.size()), 64'd0);
        check("recover_busy", 64'(busy), 64'd0);

        // Recover hits the stalled CDB entry
        do_reset();
        cdb_ready = 1'b0;
        push_fu(3, 7, 32'h700, 7, 2);
        drive_step();
        fu_wb_valid = '0;
        drive_step();
        check("rcdb_valid", 64'(cdb_valid), 64'd1);
        drive_step();
        recover_valid   = 1'b1;
        recover_rob_idx = 6'd7;
        recover_epoch   = 2'd2;
        drive_step();
        recover_valid = 1'b0;
        check("rcdb_dropped", 64'(cdb_valid), 64'd0);
        check("rcdb_busy", 64'(busy), 64'd0);

        // Flush with three buffered entries, a live CDB entry and a same-cycle push
        do_reset();
        cdb_ready = 1'b0;
        push_fu(0, 1, 32'h11, 1, 0);
        push_fu(1, 2, 32'h22, 2, 0);
        drive_step();
        push_fu(0, 3, 32'h33, 3, 0);
        push_fu(1, 4, 32'h44, 4, 0);
        drive_step();
        check("flush_pre", {cdb_valid, busy, cdb_src}, {1'b1, 1'b1, 2'd0});
        fu_wb_valid = '0;
        push_fu(2, 5, 32'h55, 5, 0);
        flush_valid = 1'b1;
        drive_step();
        flush_valid = 1'b0;
        fu_wb_valid = '0;
        check("flush_valid", 64'(cdb_valid), 64'd0);
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_ready", 64'(fu_wb_ready), 64'hF);
        cdb_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_step();
            check("flush_quiet", {cdb_valid, busy}, 2'b00);
        end
        push_fu(0, 6, 32'h66, 6, 0);
        push_fu(1, 7, 32'h77, 7, 0);
        drive_step();
        fu_wb_valid = '0;
        drive_step();
        check("flush_rr_start", {cdb_valid, cdb_src}, {1'b1, 2'd0});
        drive_step();
        drive_step();
        check("flush_after_drained", 64'(sb.size()), 64'd0);

`ifdef CDB_PERF_EN
        // Performance counters: four stalls, two broadcasts, flush leaves them alone
        do_reset();
        cdb_ready = 1'b0;
        push_fu(0, 8, 32'h88, 8, 0);
        drive_step();
        push_fu(0, 9, 32'h89, 9, 0);
        drive_step();
        fu_wb_valid = '0;
        for (int i = 0; i < 4; i++) drive_step();
        check("perf_stall4", {perf_stall_cycles, perf_bcast_count}, {32'd4, 32'd0});
        cdb_ready = 1'b1;
        drive_step();
        drive_step();
        check("perf_after_bcast", {perf_stall_cycles, perf_bcast_count}, {32'd4, 32'd2});
        flush_valid = 1'b1;
        drive_step();
        flush_valid = 1'b0;
        check("perf_after_flush", {perf_stall_cycles, perf_bcast_count}, {32'd4, 32'd2});
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
